// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, a constant clog2, and the
// address decode helpers (register index and out-of-range error).
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Word index: bits [al+iw-1:al] of the zero-extended address.
  function automatic logic [63:0] dec_index(input logic [63:0] addr, input int al, input int iw);
    return (addr >> al) & ((64'd1 << iw) - 64'd1);
  endfunction

  // Any set bit above the index field addresses a register that does not exist.
  function automatic logic dec_error(input logic [63:0] addr, input int al, input int iw);
    return |(addr >> (al + iw));
  endfunction

endpackage

// File: rtl/axi_lite_hold1.sv
// One-entry valid/ready holding register.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o   upstream handshake; in_ready_o is registered
//   in_data_i                 payload captured on handshake
//   out_valid_o, out_data_o   entry present and its payload
//   out_pop_i                 consume the entry (only meaningful while full)
module axi_lite_hold1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_pop_i
);

  logic             full_q, full_d;
  logic             ready_q;
  logic [WIDTH-1:0] data_q;
  logic             push;

  assign push = in_valid_i & ready_q;

  always_comb begin
    full_d = full_q;
    if (out_pop_i) full_d = 1'b0;
    if (push)      full_d = 1'b1;
  end

  // Ready is held low during reset and rises on the first edge after release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ~full_d;
      if (push) data_q <= in_data_i;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave with an NREG x DW register file.
// Ports:
//   ACLK, ARESET                      clock, synchronous active-high reset
//   AW*/W*/B*                         write channels (AW and W buffered independently)
//   AR*/R*                            read channels (one read outstanding)
//   reg_q                             flattened register contents, reg i at [i*DW +: DW]
//   wr_pulse                          one-cycle strobe per written register
module axi_lite_regfile_slave
  import axi_lite_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int NREG = 16
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [AW-1:0]      AWADDR,
  input  logic               WVALID,
  output logic               WREADY,
  input  logic [DW-1:0]      WDATA,
  input  logic [DW/8-1:0]    WSTRB,
  output logic               BVALID,
  input  logic               BREADY,
  output logic [1:0]         BRESP,
  input  logic               ARVALID,
  output logic               ARREADY,
  input  logic [AW-1:0]      ARADDR,
  output logic               RVALID,
  input  logic               RREADY,
  output logic [DW-1:0]      RDATA,
  output logic [1:0]         RRESP,
  output logic [NREG*DW-1:0] reg_q,
  output logic [NREG-1:0]    wr_pulse
);

  localparam int SW = DW / 8;
  localparam int AL = clog2(SW);
  localparam int IW = clog2(NREG);

  logic [DW-1:0]    regs_q [NREG];
  logic             aw_full, w_full, commit;
  logic [AW-1:0]    aw_addr;
  logic [DW+SW-1:0] w_bits;
  logic [DW-1:0]    wr_data;
  logic [SW-1:0]    wr_strb;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             wr_err, rd_err;
  logic             bvalid_q, rvalid_q, arready_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [DW-1:0]    rdata_q;
  logic [NREG-1:0]  wr_pulse_q;

  axi_lite_hold1 #(.WIDTH(AW)) u_aw_hold (
    .clk_i(ACLK), .rst_i(ARESET),
    .in_valid_i(AWVALID), .in_ready_o(AWREADY), .in_data_i(AWADDR),
    .out_valid_o(aw_full), .out_data_o(aw_addr), .out_pop_i(commit)
  );

  axi_lite_hold1 #(.WIDTH(DW + SW)) u_w_hold (
    .clk_i(ACLK), .rst_i(ARESET),
    .in_valid_i(WVALID), .in_ready_o(WREADY), .in_data_i({WSTRB, WDATA}),
    .out_valid_o(w_full), .out_data_o(w_bits), .out_pop_i(commit)
  );

  assign wr_data = w_bits[DW-1:0];
  assign wr_strb = w_bits[DW +: SW];
  assign wr_idx  = IW'(dec_index(64'(aw_addr), AL, IW));
  assign wr_err  = dec_error(64'(aw_addr), AL, IW);
  assign rd_idx  = IW'(dec_index(64'(ARADDR), AL, IW));
  assign rd_err  = dec_error(64'(ARADDR), AL, IW);

  // A commit may reuse the B slot in the same cycle the old response retires.
  assign commit = aw_full & w_full & (~bvalid_q | BREADY);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        if (!wr_err) begin
          for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) regs_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
          if (|wr_strb) wr_pulse_q[wr_idx] <= 1'b1;
        end
      end else if (BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read FSM is just RVALID/ARREADY; regs_q is sampled before any same-edge write.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (ARVALID && arready_q) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rd_err ? '0 : regs_q[rd_idx];
      rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (RREADY) rvalid_q <= 1'b0;
      arready_q <= ~rvalid_q | RREADY;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign reg_q[g*DW +: DW] = regs_q[g];
  end

  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
module tb_axi_lite_regfile_slave;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int NREG = 16;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               AWVALID, AWREADY;
  logic [AW-1:0]      AWADDR;
  logic               WVALID, WREADY;
  logic [DW-1:0]      WDATA;
  logic [DW/8-1:0]    WSTRB;
  logic               BVALID, BREADY;
  logic [1:0]         BRESP;
  logic               ARVALID, ARREADY;
  logic [AW-1:0]      ARADDR;
  logic               RVALID, RREADY;
  logic [DW-1:0]      RDATA;
  logic [1:0]         RRESP;
  logic [NREG*DW-1:0] reg_q;
  logic [NREG-1:0]    wr_pulse;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] model [NREG];

  always #5 ACLK = ~ACLK;

  axi_lite_regfile_slave #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  // ---------------- reference model (byte-addressed, 4-byte words) ----------
  function automatic logic addr_err(input logic [31:0] a);
    return a >= 32'(NREG * DW / 8);
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(NREG));
  endfunction

  function automatic logic [NREG*DW-1:0] model_flat();
    logic [NREG*DW-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic logic [NREG-1:0] exp_pulse(input logic [31:0] a, input logic [3:0] s);
    logic [NREG-1:0] p;
    p = '0;
    if (!addr_err(a) && s != 4'h0) p[addr_idx(a)] = 1'b1;
    return p;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!addr_err(a)) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[addr_idx(a)][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model[i] = '0;
  endtask

  // ---------------- drivers (no checking) ----------------------------------
  task automatic edge1();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    AWVALID = 1'b0; AWADDR = '0;
    WVALID = 1'b0; WDATA = '0; WSTRB = '0;
    ARVALID = 1'b0; ARADDR = '0;
    BREADY = 1'b1; RREADY = 1'b1;
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd,
                           output logic [1:0] resp, output logic [NREG-1:0] pulse,
                           output int lat, output logic [NREG*DW-1:0] regs_seen, output bit tmo);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    AWADDR = a; WDATA = d; WSTRB = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      AWVALID = !aw_done && cyc >= awd;
      WVALID  = !w_done && cyc >= wd;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      edge1();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      cyc++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    lat = 0;
    while (!BVALID && lat < 20) begin
      edge1();
      lat++;
    end
    tmo = !(aw_done && w_done && BVALID);
    resp = BRESP; pulse = wr_pulse; regs_seen = reg_q;
  endtask

  task automatic read_txn(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat, output bit tmo);
    int cyc;
    cyc = 0;
    ARADDR = a; ARVALID = 1'b1;
    while (!ARREADY && cyc < 20) begin
      edge1();
      cyc++;
    end
    edge1();
    ARVALID = 1'b0;
    lat = 0;
    while (!RVALID && lat < 20) begin
      edge1();
      lat++;
    end
    tmo = !RVALID || cyc >= 20;
    d = RDATA; resp = RRESP;
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    ARESET = 1'b1;
    idle_inputs();
    model_clear();
    edge1(); edge1();
    tests++; if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin fails++; $display("FAIL reset_hs: got %b expected 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID}); end
    tests++; if ({reg_q, wr_pulse, RDATA, BRESP, RRESP} !== '0) begin fails++; $display("FAIL reset_data: reg_q=%h wr_pulse=%h rdata=%h expected all 0", reg_q, wr_pulse, RDATA); end
    ARESET = 1'b0;
    edge1();
    tests++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin fails++; $display("FAIL reset_release_ready: got %b expected 111", {AWREADY, WREADY, ARREADY}); end
  endtask

  task automatic test_write_basic();
    AWVALID = 1'b1; AWADDR = 32'h08; WVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
    edge1();
    AWVALID = 1'b0; WVALID = 1'b0;
    tests++; if ({AWREADY, WREADY, BVALID} !== 3'b000) begin fails++; $display("FAIL basic_after_hs: got %b expected 000", {AWREADY, WREADY, BVALID}); end
    edge1();
    model_write(32'h08, 32'hDEADBEEF, 4'hF);
    tests++; if ({BVALID, BRESP} !== 3'b100) begin fails++; $display("FAIL basic_b: got %b expected 100", {BVALID, BRESP}); end
    tests++; if (reg_q !== model_flat()) begin fails++; $display("FAIL basic_reg: got %h expected %h", reg_q[2*DW +: DW], model[2]); end
    tests++; if (wr_pulse !== 16'h0004) begin fails++; $display("FAIL basic_pulse: got %h expected 0004", wr_pulse); end
    tests++; if ({AWREADY, WREADY} !== 2'b11) begin fails++; $display("FAIL basic_ready_back: got %b expected 11", {AWREADY, WREADY}); end
    edge1();
    tests++; if ({BVALID, wr_pulse} !== '0) begin fails++; $display("FAIL basic_clear: bvalid=%b pulse=%h expected 0", BVALID, wr_pulse); end
  endtask

  task automatic test_w_first();
    WVALID = 1'b1; WDATA = 32'h000000AA; WSTRB = 4'h1;
    edge1();
    WVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tests++; if ({BVALID, WREADY, AWREADY} !== 3'b001) begin fails++; $display("FAIL wfirst_wait: got %b expected 001", {BVALID, WREADY, AWREADY}); end
      edge1();
    end
    AWVALID = 1'b1; AWADDR = 32'h08;
    edge1();
    AWVALID = 1'b0;
    tests++; if (BVALID !== 1'b0) begin fails++; $display("FAIL wfirst_early: got %b expected 0", BVALID); end
    edge1();
    model_write(32'h08, 32'h000000AA, 4'h1);
    tests++; if (BVALID !== 1'b1 || reg_q[2*DW +: DW] !== 32'hDEADBEAA) begin fails++; $display("FAIL wfirst_commit: bvalid=%b reg2=%h expected 1 deadbeaa", BVALID, reg_q[2*DW +: DW]); end
    tests++; if (wr_pulse !== 16'h0004) begin fails++; $display("FAIL wfirst_pulse: got %h expected 0004", wr_pulse); end
    edge1();
  endtask

  task automatic test_error();
    logic [1:0] resp; logic [NREG-1:0] pulse; int lat; logic [NREG*DW-1:0] rs; bit tmo;
    logic [31:0] d, a;
    a = 32'h100;
    for (int k = 0; k < 3; k++) begin
      write_txn(a, $urandom, 4'hF, 0, 0, resp, pulse, lat, rs, tmo);
      tests++; if (tmo || resp !== 2'b10 || pulse !== '0 || rs !== model_flat()) begin fails++; $display("FAIL err_write: addr=%h tmo=%0d resp=%b pulse=%h expected resp 10, no change", a, tmo, resp, pulse); end
      read_txn(a, d, resp, lat, tmo);
      tests++; if (tmo || d !== '0 || resp !== 2'b10) begin fails++; $display("FAIL err_read: addr=%h rdata=%h rresp=%b expected 0 10", a, d, resp); end
      a = $urandom | 32'h40;
    end
  endtask

  task automatic test_bready_stall();
    logic [31:0] a2, d2; logic [3:0] s2;
    a2 = 32'($urandom_range(0, NREG * 4 - 1)); d2 = $urandom; s2 = 4'($urandom_range(1, 15));
    BREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 32'h0000_0400; WVALID = 1'b1; WDATA = $urandom; WSTRB = 4'hF;
    edge1();
    AWVALID = 1'b0; WVALID = 1'b0;
    edge1();
    tests++; if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b11011) begin fails++; $display("FAIL stall_first: got %b expected 11011", {BVALID, BRESP, AWREADY, WREADY}); end
    AWVALID = 1'b1; AWADDR = a2; WVALID = 1'b1; WDATA = d2; WSTRB = s2;
    edge1();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++; if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b11000 || reg_q !== model_flat()) begin fails++; $display("FAIL stall_hold: cycle %0d got %b expected 11000", i, {BVALID, BRESP, AWREADY, WREADY}); end
      edge1();
    end
    BREADY = 1'b1;
    edge1();
    model_write(a2, d2, s2);
    tests++; if ({BVALID, BRESP} !== 3'b100 || reg_q !== model_flat()) begin fails++; $display("FAIL stall_commit: b=%b resp=%b reg_q ok=%0d expected 1 00 1", BVALID, BRESP, reg_q === model_flat()); end
    tests++; if (wr_pulse !== exp_pulse(a2, s2)) begin fails++; $display("FAIL stall_pulse: got %h expected %h", wr_pulse, exp_pulse(a2, s2)); end
    edge1();
    tests++; if (BVALID !== 1'b0) begin fails++; $display("FAIL stall_retire: got %b expected 0", BVALID); end
  endtask

  task automatic test_read_collision();
    logic [31:0] d; logic [1:0] resp; int lat; bit tmo;
    AWVALID = 1'b1; AWADDR = 32'h08; WVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF;
    edge1();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = 32'h08;
    edge1();
    ARVALID = 1'b0;
    tests++; if ({RVALID, RRESP} !== 3'b100 || RDATA !== 32'hDEADBEAA) begin fails++; $display("FAIL collide_old: rvalid=%b rdata=%h expected 1 deadbeaa", RVALID, RDATA); end
    model_write(32'h08, 32'h12345678, 4'hF);
    tests++; if (BVALID !== 1'b1 || reg_q !== model_flat()) begin fails++; $display("FAIL collide_write: bvalid=%b reg2=%h expected 1 12345678", BVALID, reg_q[2*DW +: DW]); end
    edge1();
    read_txn(32'h08, d, resp, lat, tmo);
    tests++; if (tmo || d !== 32'h12345678 || resp !== 2'b00) begin fails++; $display("FAIL collide_new: rdata=%h rresp=%b expected 12345678 00", d, resp); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp; logic [NREG-1:0] pulse; int lat; logic [NREG*DW-1:0] rs; bit tmo;
    logic [31:0] a, d; logic [3:0] s; time t0; bit any_tmo;
    any_tmo = 0;
    t0 = $time;
    for (int k = 0; k < 4; k++) begin
      a = 32'($urandom_range(0, NREG * 4 - 1)); d = $urandom; s = 4'hF;
      write_txn(a, d, s, 0, 0, resp, pulse, lat, rs, tmo);
      model_write(a, d, s);
      any_tmo |= tmo;
    end
    tests++; if (any_tmo || ($time - t0) != 80) begin fails++; $display("FAIL b2b_write_rate: elapsed %0t expected 80", $time - t0); end
    read_txn(32'h0, d, resp, lat, tmo);
    t0 = $time;
    for (int k = 0; k < 4; k++) begin
      read_txn(32'($urandom_range(0, NREG * 4 - 1)), d, resp, lat, tmo);
      any_tmo |= tmo;
    end
    tests++; if (any_tmo || ($time - t0) != 80) begin fails++; $display("FAIL b2b_read_rate: elapsed %0t expected 80", $time - t0); end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [NREG-1:0] pulse; int lat; logic [NREG*DW-1:0] rs; bit tmo;
    logic [31:0] a, d, exp_d; logic [3:0] s;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom; if (a < 32'(NREG * 4)) a = a + 32'(NREG * 4);
      end else begin
        a = 32'($urandom_range(0, NREG * 4 - 1));
      end
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        write_txn(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp, pulse, lat, rs, tmo);
        model_write(a, d, s);
        tests++; if (tmo || lat != 1 || resp !== (addr_err(a) ? 2'b10 : 2'b00)) begin fails++; $display("FAIL rnd_write_b: addr=%h tmo=%0d lat=%0d resp=%b expected lat 1 err %b", a, tmo, lat, resp, addr_err(a)); end
        tests++; if (pulse !== exp_pulse(a, s) || rs !== model_flat()) begin fails++; $display("FAIL rnd_write_state: addr=%h strb=%h pulse=%h expected %h reg_q ok=%0d", a, s, pulse, exp_pulse(a, s), rs === model_flat()); end
      end else begin
        read_txn(a, d, resp, lat, tmo);
        exp_d = addr_err(a) ? 32'h0 : model[addr_idx(a)];
        tests++; if (tmo || lat != 0 || d !== exp_d || resp !== (addr_err(a) ? 2'b10 : 2'b00)) begin fails++; $display("FAIL rnd_read: addr=%h rdata=%h rresp=%b expected %h err %b", a, d, resp, exp_d, addr_err(a)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    d = $urandom;
    BREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 32'h0C; WVALID = 1'b1; WDATA = $urandom; WSTRB = 4'hF;
    edge1();
    AWVALID = 1'b0; WVALID = 1'b0;
    edge1();
    ARVALID = 1'b1; ARADDR = 32'h0C;
    AWVALID = 1'b1; AWADDR = 32'h10;
    edge1();
    AWVALID = 1'b0; ARVALID = 1'b0;
    tests++; if ({BVALID, AWREADY, RVALID} !== 3'b101) begin fails++; $display("FAIL rstmid_setup: got %b expected 101", {BVALID, AWREADY, RVALID}); end
    ARESET = 1'b1; RREADY = 1'b0;
    edge1();
    tests++; if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse, BRESP, RRESP, RDATA, reg_q} !== '0) begin fails++; $display("FAIL rstmid_zero: hs=%b rdata=%h reg_q=%h expected 0", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, RDATA, reg_q); end
    ARESET = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    model_clear();
    edge1();
    tests++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin fails++; $display("FAIL rstmid_ready: got %b expected 111", {AWREADY, WREADY, ARREADY}); end
    WVALID = 1'b1; WDATA = d; WSTRB = 4'hF;
    edge1();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (BVALID !== 1'b0 || reg_q !== '0) begin fails++; $display("FAIL rstmid_nocommit: bvalid=%b reg_q=%h expected 0", BVALID, reg_q); end
      edge1();
    end
    AWVALID = 1'b1; AWADDR = 32'h10;
    edge1();
    AWVALID = 1'b0;
    edge1();
    model_write(32'h10, d, 4'hF);
    tests++; if (BVALID !== 1'b1 || reg_q !== model_flat()) begin fails++; $display("FAIL rstmid_resume: bvalid=%b reg4=%h expected 1 %h", BVALID, reg_q[4*DW +: DW], d); end
    edge1();
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_w_first();
    test_error();
    test_bready_stall();
    test_read_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_lite_regfile_slave.md
# axi_lite_regfile_slave

Parametrised AXI4-Lite slave with an internal register file of NREG words of DW bits: byte-strobed writes, SLVERR on out-of-range addresses, independently accepted AW and W channels, and per-register write strobes to the user logic. It replaces the fixed 32-bit single-register-port slave. It sits between the AXI-Lite interconnect and the peripheral control logic, which reads the flattened register outputs directly.

## Interface
- DW, 32: data width; 32 or 64.
- AW, 32: address width.
- NREG, 16: register count; a power of two, ≥2.
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- AWVALID/AWREADY  in/out  1  write address handshake; AWADDR  in  AW.
- WVALID/WREADY  in/out  1  write data handshake; WDATA  in  DW; WSTRB  in  DW/8.
- BVALID/BREADY  out/in  1  write response handshake; BRESP  out  2.
- ARVALID/ARREADY  in/out  1  read address handshake; ARADDR  in  AW.
- RVALID/RREADY  out/in  1  read data handshake; RDATA  out  DW; RRESP  out  2.
- reg_q  out  NREG*DW  flattened register contents; register i is at [i*DW +: DW].
- wr_pulse  out  NREG  one-cycle strobe marking the register written.

## Operation
- Decode: AL = log2(DW/8) and IW = log2(NREG). The index is ADDR[AL+IW-1:AL]. ADDR[AL-1:0] is ignored. Any nonzero bit in ADDR[AW-1:AL+IW] is an error and gives RESP 2'b10 (SLVERR); otherwise RESP is 2'b00.
- Write path: AW and W each have a one-entry holding buffer.
  - AWREADY = AW buffer empty; WREADY = W buffer empty. Both are registered.
  - Either channel may handshake first or both in the same cycle.
- Commit: at an edge where both buffers are full and the B slot is free (BVALID=0, or BVALID&BREADY in that cycle):
  - Bytes with WSTRB set are written to the decoded register.
  - BVALID is set and BRESP is loaded.
  - Both buffers empty.
  - wr_pulse[idx] is raised for one cycle if the write has no error and at least one strobe is set.
- Errored write: no register change and no wr_pulse. BRESP is 2'b10.
- Read path: one read outstanding.
  - ARREADY = ~RVALID, registered.
  - At the AR handshake edge, RDATA = reg[idx] (0 on error), RRESP is loaded, and RVALID goes to 1.
  - RVALID&RREADY clears RVALID at that edge.
- Read and write are independent. If an AR handshake and a write commit hit the same register on the same edge, RDATA returns the pre-write value.
- RDATA, RRESP and BRESP hold stable while their VALID is high and READY is low.

## Timing
- While ARESET is high at an edge: all registers go to 0; all READY, VALID and wr_pulse outputs go to 0; RDATA and the RESP outputs go to 0.
- The first edge after reset release sets AWREADY, WREADY and ARREADY to 1.
- Reset mid-transaction discards buffered AW/W entries and any pending B or R response, with no commit.
- Write latency:
  - With AW and W handshaked at edge E0 and BREADY=1, commit and BVALID occur at E1, and reg_q reflects the new value after E1.
  - AWREADY and WREADY return high after E1.
  - Sustained throughput is 1 write per 2 cycles.
- If W arrives k cycles after AW, the commit occurs one edge after the W handshake. AWREADY stays low while the AW buffer waits.
- BREADY held low stalls the next commit; a full buffer keeps its READY low.
- Read latency: RVALID is high one edge after the AR handshake. With RREADY=1, sustained throughput is 1 read per 2 cycles.
- wr_pulse is registered, asserted in the same cycle as BVALID's first cycle.

## Structure
- Shared package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - A clog2 function.
  - The decode helper (index and error), shared with future AXI-Lite slaves.
- Sub-module axi_lite_hold1: a one-entry valid/ready holding register with parameter WIDTH. It is instantiated twice: AW (AW bits) and W (DW + DW/8 bits).
- The register file, commit logic and read FSM live in the top module.

## Test plan
- Reset, then AWADDR=0x08, WDATA=0xDEADBEEF, WSTRB=4'hF, all in one cycle, BREADY=1 -> BVALID one cycle later with BRESP=00; reg_q[2] = 0xDEADBEEF; wr_pulse=16'h0004 for one cycle.
- W (0x000000AA, WSTRB=4'h1) first, AW to 0x08 three cycles later -> commit one edge after the AW handshake; reg_q[2] = 0xDEADBEAA.
- AWADDR=0x100 (NREG=16) -> BRESP=10, no register changes, wr_pulse=0. ARADDR=0x100 -> RDATA=0, RRESP=10.
- BREADY held low for 5 cycles with a second write queued -> BVALID and BRESP stable; AWREADY and WREADY low after the second handshake; the second commit occurs on the edge BREADY is sampled high.
- AR to 0x08 on the same edge as a write commit to 0x08 (0x12345678) -> RDATA returns the old 0xDEADBEAA; a subsequent read returns 0x12345678.
- ARESET pulsed while BVALID=1 and AW is buffered -> all outputs are 0; READY outputs are 1 one edge after release; no commit of the buffered address.
